// File: rtl/inst_cache_arbiter.sv
// Arbiter/sequencer sharing the instruction cache port between fetch reads and loader writes.
// Each transaction is IDLE -> ACCESS -> RESP. Every address is range-checked, and the cache inputs are held stable around writes.
`ifndef _INST_CACHE_SIZE
`define _INST_CACHE_SIZE 32'd1023
`endif
`ifndef _INST_CACHE_OFFSET
`define _INST_CACHE_OFFSET 32'd0
`endif

module inst_cache_arbiter #(
    parameter logic [31:0] CACHE_SIZE      = `_INST_CACHE_SIZE,
    parameter logic [31:0] CACHE_OFFSET    = `_INST_CACHE_OFFSET,
    parameter int          MAX_WRITE_BURST = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_addr,
    output logic        o_fetch_ack,
    output logic [31:0] o_fetch_val,
    output logic        o_fetch_err,
    input  logic        i_load_req,
    input  logic [31:0] i_load_addr,
    input  logic [31:0] i_load_val,
    output logic        o_load_ack,
    output logic        o_load_err,
    output logic [31:0] o_cache_address,
    output logic [31:0] o_cache_val,
    output logic        o_cache_op_type,
    input  logic [31:0] i_cache_val,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  burst_cnt;
    logic        sel_load, lat_ok;
    logic [31:0] cache_addr, cache_val, fetch_val;
    logic        grant_load, grant_fetch;
    logic [31:0] req_addr;
    logic        req_ok;

    // Use 33-bit arithmetic so that addresses near 2^32 cannot wrap into range.
    function automatic logic addr_ok(input logic [31:0] a);
        logic [32:0] top;
        top = {1'b0, a} - {1'b0, CACHE_OFFSET} + 33'd3;
        return (a[1:0] == 2'b00) && (a >= CACHE_OFFSET) && (top <= {1'b0, CACHE_SIZE});
    endfunction

    always_comb begin
        grant_load  = (state == IDLE) && i_load_req &&
                      !(i_fetch_req && (burst_cnt == 4'(MAX_WRITE_BURST)));
        grant_fetch = (state == IDLE) && i_fetch_req && !grant_load;
        req_addr    = grant_load ? i_load_addr : i_fetch_addr;
        req_ok      = addr_ok(req_addr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            burst_cnt  <= 4'd0;
            sel_load   <= 1'b0;
            lat_ok     <= 1'b0;
            cache_addr <= CACHE_OFFSET;
            cache_val  <= 32'd0;
            fetch_val  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (grant_load)
                burst_cnt <= i_fetch_req ? burst_cnt + 4'd1 : 4'd0;
            else if (grant_fetch)
                burst_cnt <= 4'd0;
            if (grant_load || grant_fetch) begin
                sel_load <= grant_load;
                lat_ok   <= req_ok;
                // The cache must not see a rejected address, so keep the last valid one.
                if (req_ok)
                    cache_addr <= req_addr;
                if (grant_load && req_ok)
                    cache_val <= i_load_val;
            end
            if (state == ACCESS && !sel_load)
                fetch_val <= lat_ok ? i_cache_val : 32'd0;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = (grant_load || grant_fetch) ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_cache_address = cache_addr;
        o_cache_val     = cache_val;
        o_cache_op_type = (state == ACCESS) && sel_load && lat_ok;
        o_fetch_ack     = (state == RESP) && !sel_load;
        o_fetch_err     = (state == RESP) && !sel_load && !lat_ok;
        o_fetch_val     = fetch_val;
        o_load_ack      = (state == RESP) && sel_load;
        o_load_err      = (state == RESP) && sel_load && !lat_ok;
        o_busy          = (state != IDLE);
    end
endmodule

// File: tb/tb_inst_cache_arbiter.sv
// Bench for inst_cache_arbiter: models the cache array, runs directed and random transactions,
// and checks them against a transaction-level reference of the memory and the arbitration rules.
module tb_inst_cache_arbiter;
    localparam logic [31:0] SIZE = 32'd255;
    localparam logic [31:0] OFF  = 32'd0;
    localparam int          MAXB = 4;
    localparam int          WORDS = 64;

    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        i_fetch_req = 1'b0, i_load_req = 1'b0;
    logic [31:0] i_fetch_addr = '0, i_load_addr = '0, i_load_val = '0;
    logic        o_fetch_ack, o_fetch_err, o_load_ack, o_load_err, o_cache_op_type, o_busy;
    logic [31:0] o_fetch_val, o_cache_address, o_cache_val, i_cache_val;

    logic        preload = 1'b1;
    logic [31:0] cmem    [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic [31:0] last_valid;
    int vectors = 0, miscompares = 0;

    inst_cache_arbiter #(.CACHE_SIZE(SIZE), .CACHE_OFFSET(OFF), .MAX_WRITE_BURST(MAXB)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
        .o_fetch_ack(o_fetch_ack), .o_fetch_val(o_fetch_val), .o_fetch_err(o_fetch_err),
        .i_load_req(i_load_req), .i_load_addr(i_load_addr), .i_load_val(i_load_val),
        .o_load_ack(o_load_ack), .o_load_err(o_load_err),
        .o_cache_address(o_cache_address), .o_cache_val(o_cache_val),
        .o_cache_op_type(o_cache_op_type), .i_cache_val(i_cache_val), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] payload(input int i);
        return 32'hA5C30000 ^ (i * 32'h01010101);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] r;
        r = (a - OFF) >> 2;
        return int'(r[5:0]);
    endfunction

    // Behavioural cache: combinational read and a synchronous write while op_type is high.
    assign i_cache_val = cmem[widx(o_cache_address)];
    always @(posedge i_clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) cmem[i] <= payload(i);
        end else if (o_cache_op_type) begin
            cmem[widx(o_cache_address)] <= o_cache_val;
        end
    end

    function automatic bit ok_model(input logic [31:0] a);
        longint unsigned la;
        la = a;
        return (la % 4 == 0) && (la >= OFF) && (la - OFF + 3 <= SIZE);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_txn(input bit ld, input logic [31:0] a, input logic [31:0] d);
        bit ok, got;
        int n;
        logic [31:0] acc_addr;
        ok = ok_model(a);
        got = 0; n = 0; acc_addr = '0;
        if (ld) begin i_load_req = 1; i_load_addr = a; i_load_val = d; end
        else    begin i_fetch_req = 1; i_fetch_addr = a; end
        while (!got && n < 8) begin
            tick();
            n++;
            if (n == 1) begin
                chk("access_op", o_cache_op_type, (ld && ok) ? 1 : 0);
                chk("access_addr", o_cache_address, ok ? a : last_valid);
                acc_addr = o_cache_address;
            end
            got = ld ? o_load_ack : o_fetch_ack;
        end
        chk("ack_seen", got, 1);
        chk("latency", n, 2);
        if (got) begin
            chk("resp_op", o_cache_op_type, 0);
            chk("resp_addr_stable", o_cache_address, acc_addr);
            if (ld) begin
                chk("load_err", o_load_err, ok ? 0 : 1);
                chk("other_ack", o_fetch_ack, 0);
            end else begin
                chk("fetch_err", o_fetch_err, ok ? 0 : 1);
                chk("fetch_val", o_fetch_val, ok ? ref_mem[widx(a)] : 32'd0);
                chk("other_ack", o_load_ack, 0);
            end
        end
        if (ld && ok) ref_mem[widx(a)] = d;
        if (ok) last_valid = a;
        i_load_req = 0; i_fetch_req = 0;
        tick();
        chk("idle_after", o_busy, 0);
    endtask

    task automatic chk_reset_outputs;
        chk("rst_op", o_cache_op_type, 0);
        chk("rst_addr", o_cache_address, OFF);
        chk("rst_cval", o_cache_val, 0);
        chk("rst_acks", {o_fetch_ack, o_load_ack}, 0);
        chk("rst_errs", {o_fetch_err, o_load_err}, 0);
        chk("rst_fval", o_fetch_val, 0);
        chk("rst_busy", o_busy, 0);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = payload(i);
        last_valid = OFF;
        tick(); tick();
        chk_reset_outputs();
        i_rst = 0; preload = 0;
        tick();

        // Directed accesses and range boundaries.
        do_txn(0, 32'h0, 0);
        do_txn(1, 32'h10, 32'hDEADBEEF);
        do_txn(0, 32'h10, 0);
        do_txn(0, 32'h12, 0);
        do_txn(1, SIZE - 1, 32'h12345678);
        do_txn(1, 32'hFFFFFFFC, 32'h87654321);
        do_txn(1, SIZE - 3, 32'hCAFEF00D);
        do_txn(1, SIZE + 1, 32'h0BADF00D);
        do_txn(0, SIZE - 3, 0);
        do_txn(0, 32'h100, 0);

        // Both requesters held: loader gets MAXB grants, then fetch gets one.
        begin
            int streak, nacks, cyc, last_cyc;
            bit exp_load;
            streak = 0; nacks = 0; cyc = 0; last_cyc = 0;
            i_load_req = 1; i_load_addr = 32'h20; i_load_val = 32'h5A5A1234;
            i_fetch_req = 1; i_fetch_addr = 32'h24;
            while (nacks < 10 && cyc < 60) begin
                tick();
                cyc++;
                if (o_load_ack || o_fetch_ack) begin
                    exp_load = (streak != MAXB);
                    streak = exp_load ? streak + 1 : 0;
                    chk("arb_winner", o_load_ack, exp_load);
                    chk("arb_gap", cyc - last_cyc, (nacks == 0) ? 2 : 3);
                    if (o_load_ack) ref_mem[8] = 32'h5A5A1234;
                    else chk("arb_fetch_val", o_fetch_val, ref_mem[9]);
                    last_cyc = cyc;
                    nacks++;
                end
            end
            chk("arb_count", nacks, 10);
            i_load_req = 0; i_fetch_req = 0;
            tick(); tick();
            last_valid = 32'h20;
        end

        // Reset during the ACCESS cycle of a write.
        i_load_req = 1; i_load_addr = 32'h30; i_load_val = 32'h11223344;
        tick();
        chk("mid_access_op", o_cache_op_type, 1);
        i_rst = 1; i_load_req = 0;
        tick();
        chk_reset_outputs();
        i_rst = 0;
        last_valid = OFF;
        tick();
        chk("post_rst_idle", o_busy, 0);
        do_txn(1, 32'h30, 32'h11223344);
        do_txn(0, 32'h30, 0);

        // Random mix of reads and writes over valid, misaligned and out-of-range addresses.
        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0, 1: a = OFF + ($urandom_range(0, WORDS - 1) << 2);
                2:    a = OFF + ($urandom_range(0, WORDS - 1) << 2) + $urandom_range(1, 3);
                default: a = $urandom;
            endcase
            do_txn($urandom_range(0, 1) == 1, a, $urandom);
        end

        for (int i = 0; i < WORDS; i++) chk($sformatf("mem[%0d]", i), cmem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/inst_cache_arbiter.md
# inst_cache_arbiter

Sequencer and arbiter in front of the instruction cache. It shares the cache's single read/write port between the fetch stage (reads) and the program loader (writes). It range-checks every access and holds the cache address, data and op-type stable around each write. Results return to each requester through a req/ack handshake with registered data.

## Interface
Parameters:
- CACHE_SIZE, `_INST_CACHE_SIZE, highest valid byte index of the cache array
- CACHE_OFFSET, `_INST_CACHE_OFFSET, byte address mapped to cache index 0
- MAX_WRITE_BURST, 4, consecutive loader grants allowed while a fetch is waiting (1..15)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_fetch_req  in  1  fetch read request; held until o_fetch_ack
- i_fetch_addr  in  32  fetch byte address
- o_fetch_ack  out  1  one-cycle pulse: read finished
- o_fetch_val  out  32  read data, valid while o_fetch_ack=1
- o_fetch_err  out  1  valid with ack: address out of range or misaligned
- i_load_req  in  1  loader write request; held until o_load_ack
- i_load_addr  in  32  loader byte address
- i_load_val  in  32  loader write word
- o_load_ack  out  1  one-cycle pulse: write finished
- o_load_err  out  1  valid with ack: address rejected, no write done
- o_cache_address  out  32  to cache i_address
- o_cache_val  out  32  to cache i_val
- o_cache_op_type  out  1  to cache i_op_type (0 read, 1 write)
- i_cache_val  in  32  from cache o_val
- o_busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE → ACCESS on a grant.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Grant happens in IDLE when either request is high.
  - Only one request high: that requester wins.
  - Both high: loader wins, unless burst_cnt == MAX_WRITE_BURST; then fetch wins.
- burst_cnt (4 bits):
  - Increments on a loader grant while i_fetch_req=1.
  - Clears on any fetch grant.
  - Clears on any loader grant while i_fetch_req=0.
- At grant, latch into internal registers: requester id, address, write data (loader only), and addr_ok.
- addr_ok requires all of:
  - addr[1:0]==0
  - addr >= CACHE_OFFSET
  - addr − CACHE_OFFSET + 3 <= CACHE_SIZE
  - The compare is done in 33-bit arithmetic, so wrap-around never passes the check.
- ACCESS cycle:
  - o_cache_address = latched address, o_cache_val = latched data.
  - o_cache_op_type = 1 only for a loader grant with addr_ok=1; otherwise 0.
- RESP cycle:
  - o_cache_op_type = 0. Address and data stay unchanged from ACCESS, so the cache never sees an address change while op_type=1.
  - Ack of the granted requester = 1.
  - Fetch with addr_ok: o_fetch_val = i_cache_val sampled at the end of ACCESS, o_fetch_err = 0.
  - Fetch without addr_ok: o_fetch_val = 0, o_fetch_err = 1.
  - Loader without addr_ok: o_load_err = 1.
- Rejected accesses never drive op_type=1. The cache address stays at the previous valid value; it is not changed to the rejected address.
- Requesters drop or change req in the cycle after ack. A req still high in RESP is re-evaluated in IDLE as a new request.

## Timing
- Reset (edge where i_rst=1, from any state, including mid-ACCESS) sets:
  - state = IDLE, burst_cnt = 0
  - o_cache_op_type = 0, o_cache_address = CACHE_OFFSET, o_cache_val = 0
  - both acks = 0, both errs = 0, o_fetch_val = 0, o_busy = 0
- An interrupted write may have partially updated the cache. The loader must reissue it; no ack is given.
- Request seen at edge N (state IDLE) → ACCESS during cycle N+1 → ack high during cycle N+2 → IDLE at N+3.
- Throughput: one transaction per 3 cycles. Minimum request-to-ack latency is 2 cycles.
- Outside RESP: acks and errs = 0. o_fetch_val holds its last value.
- A request that arrives during ACCESS or RESP waits. It is not lost, because req stays high until its ack.
- A write followed by a read of the same address returns the new word; the write completed in the earlier ACCESS cycle.

## Test plan
- Reset with CACHE_OFFSET=0 → all outputs at reset values, o_busy=0. Then fetch 0x0 → ack at cycle +2 with the preloaded payload word, err=0.
- Load 0x10 ← 0xDEADBEEF, then fetch 0x10 → load_ack at +2, fetch_val=0xDEADBEEF. op_type=1 for exactly one cycle, and o_cache_address stays stable across ACCESS and RESP.
- Fetch and load both held high continuously, MAX_WRITE_BURST=4 → grant order L,L,L,L,F,L,L,L,L,F.
- Fetch 0x12 (misaligned), then load at CACHE_SIZE−1 (overflow) → each ack has err=1, fetch_val=0, op_type never 1, cache contents unchanged.
- Assert i_rst during ACCESS of a write → next cycle IDLE, op_type=0, no ack. Reissue the write → completes normally.
- Load 0xFFFFFFFC → err=1; wrap-around is not accepted.
